pmem_burst_responder: RTL and testbench
=======================================

PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request acceptance to first data beat (0..15).
REQ-002 SHALL have parameter DEPTH_LINES, default 256, number of 256-bit lines stored (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port mem_address  input  32  byte address; bits [4:0] ignored (line-aligned).
REQ-006 SHALL have port mem_read  input  1  burst read request, held until burst completes.
REQ-007 SHALL have port mem_write  input  1  burst write request, held until burst completes.
REQ-008 SHALL have port mem_byte_enable  input  4  per-byte write mask applied to every write beat.
REQ-009 SHALL have port mem_wdata  input  32  write beat data, sampled on cycles with mem_resp=1.
REQ-010 SHALL have port mem_rdata  output  32  read beat data, valid on cycles with mem_resp=1.
REQ-011 SHALL have port mem_resp  output  1  per-beat strobe, high for each of the 8 beats.
REQ-012 SHALL have port protocol_err  output  1  one-cycle pulse on illegal request.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, BURST, DONE.
REQ-014 IDLE: exactly one of mem_read/mem_write high -> latch line index (mem_address[4+log2(DEPTH_LINES):5]) and op, load latency counter, go WAIT (or BURST directly if LATENCY=0).
REQ-015 WAIT: decrement latency counter each cycle; on reaching 0 go BURST with beat counter = 0.
REQ-016 BURST: mem_resp=1 every cycle for 8 consecutive cycles, beat counter 0..7; after beat 7 go DONE.
REQ-017 Read beat i: mem_rdata = word i (bits [32i+31:32i]) of latched line, registered, aligned with mem_resp.
REQ-018 Write beat i: bytes of word i with mem_byte_enable[b]=1 updated from mem_wdata on that edge; others unchanged.
REQ-019 DONE: mem_resp=0 for one cycle, return IDLE; a request still asserted in DONE is NOT re-accepted until seen in IDLE.
REQ-020 mem_read and mem_write both high in IDLE -> no acceptance, protocol_err=1 for that cycle, stay IDLE.
REQ-021 Requested op deasserted during WAIT or BURST -> abort: next cycle IDLE, mem_resp=0, already-written beats retained.
REQ-022 Address line index wraps modulo DEPTH_LINES; address bits above index ignored.
REQ-023 mem_address and mem_byte_enable changes after acceptance SHALL be ignored for the rest of the burst.
REQ-024 mem_rdata SHALL hold 0 whenever mem_resp=0.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, mem_resp=0, mem_rdata=0, protocol_err=0, counters 0.
REQ-026 Reset mid-burst SHALL abort the burst; storage array contents SHALL NOT be cleared by reset.
REQ-027 First request SHALL be accepted no earlier than the first rising edge after rst returns high.

Structure
REQ-028 Package pmem_pkg SHALL hold BEATS=8, WORD_BITS=32, LINE_BITS=256, BE_BITS=4, and the FSM state enum.
REQ-029 Storage SHALL be sub-module pmem_line_ram: DEPTH_LINES x 8 words, one synchronous read port, one byte-masked write port, no reset.
REQ-030 Beat counter 3 bits, latency counter 4 bits; no other sequential state beyond FSM and latched request.

Verification
REQ-031 Write line 0x40 beats 0x11111111..0x88888888, BE=0xF, then read 0x40 -> 8 resp beats returning same words in order, first resp LATENCY+1 cycles after request.
REQ-032 Write 0xFFFFFFFF BE=0xF to line 0x80, then write 0x00000000 BE=0x5 -> read returns 0xFF00FF00 every beat.
REQ-033 mem_read=mem_write=1 in IDLE -> protocol_err one cycle, mem_resp stays 0.
REQ-034 Drop mem_read after beat 3 -> mem_resp low next cycle, FSM IDLE, new read accepted normally.
REQ-035 Assert rst=0 during beat 5 of a write -> outputs 0 asynchronously; later read shows beats 0-4 updated, 5-7 old values.
REQ-036 LATENCY=0 build, read 0x1FE0 with DEPTH_LINES=256 -> first beat next cycle, data from line index 0xFF.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared constants and FSM state encoding for the burst memory responder.
package pmem_pkg;

    localparam int unsigned BEATS     = 8;
    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned BE_BITS   = 4;
    localparam int unsigned BEAT_W    = 3;
    localparam int unsigned LAT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_e;

endpackage

// File: rtl/pmem_line_ram.sv
// Word-addressed line storage: {line, beat} address, registered read, byte-masked write.
module pmem_line_ram
    import pmem_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic                                   clk,
    input  logic [$clog2(DEPTH_LINES)+BEAT_W-1:0]  raddr,
    output logic [WORD_BITS-1:0]                   rdata,
    input  logic                                   we,
    input  logic [$clog2(DEPTH_LINES)+BEAT_W-1:0]  waddr,
    input  logic [BE_BITS-1:0]                     be,
    input  logic [WORD_BITS-1:0]                   wdata
);

    logic [WORD_BITS-1:0] mem [DEPTH_LINES*BEATS];

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) begin
            for (int unsigned b = 0; b < BE_BITS; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/pmem_burst_responder.sv
// Burst-mode memory responder: 8-beat line reads/writes after a fixed latency.
module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [BE_BITS-1:0]    mem_byte_enable,
    input  logic [WORD_BITS-1:0]  mem_wdata,
    output logic [WORD_BITS-1:0]  mem_rdata,
    output logic                  mem_resp,
    output logic                  protocol_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam logic [LAT_W-1:0] LAT_INIT = 4'(LATENCY);

    state_e              state, state_nxt;
    logic [IDX_W-1:0]    line_q, line_nxt;
    logic                op_wr_q, op_wr_nxt;
    logic [BE_BITS-1:0]  be_q, be_nxt;
    logic [LAT_W-1:0]    lat_q, lat_nxt;
    logic [BEAT_W-1:0]   beat_q, beat_nxt;

    logic [IDX_W-1:0]    req_line;
    logic                op_held;
    logic                ram_we;
    logic [IDX_W-1:0]    rd_line;
    logic [BEAT_W-1:0]   rd_beat;
    logic [WORD_BITS-1:0] ram_q;
    logic                unused_addr_bits;

    assign req_line         = mem_address[5 +: IDX_W];
    assign op_held          = op_wr_q ? mem_write : mem_read;
    assign unused_addr_bits = ^{mem_address[31:IDX_W+5], mem_address[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            line_q  <= '0;
            op_wr_q <= 1'b0;
            be_q    <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state   <= state_nxt;
            line_q  <= line_nxt;
            op_wr_q <= op_wr_nxt;
            be_q    <= be_nxt;
            lat_q   <= lat_nxt;
            beat_q  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        line_nxt     = line_q;
        op_wr_nxt    = op_wr_q;
        be_nxt       = be_q;
        lat_nxt      = lat_q;
        beat_nxt     = beat_q;
        ram_we       = 1'b0;
        protocol_err = 1'b0;
        // The RAM read is registered, so the address leads the beat by one cycle.
        rd_line      = line_q;
        rd_beat      = '0;

        unique case (state)
            IDLE: begin
                rd_line = req_line;
                if (mem_read && mem_write) begin
                    protocol_err = rst;
                end else if (mem_read || mem_write) begin
                    line_nxt  = req_line;
                    op_wr_nxt = mem_write;
                    be_nxt    = mem_byte_enable;
                    lat_nxt   = LAT_INIT;
                    beat_nxt  = '0;
                    state_nxt = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!op_held) begin
                    state_nxt = IDLE;
                    lat_nxt   = '0;
                end else if (lat_q <= 4'd1) begin
                    state_nxt = BURST;
                    lat_nxt   = '0;
                    beat_nxt  = '0;
                end else begin
                    lat_nxt = lat_q - 4'd1;
                end
            end
            BURST: begin
                rd_beat = beat_q + 3'd1;
                if (!op_held) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end else begin
                    ram_we = op_wr_q;
                    if (beat_q == 3'd7) begin
                        state_nxt = DONE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    pmem_line_ram #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_ram (
        .clk   (clk),
        .raddr ({rd_line, rd_beat}),
        .rdata (ram_q),
        .we    (ram_we),
        .waddr ({line_q, beat_q}),
        .be    (be_q),
        .wdata (mem_wdata)
    );

    assign mem_resp  = (state == BURST);
    assign mem_rdata = (state == BURST && !op_wr_q) ? ram_q : '0;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed and randomized burst traffic against two builds (LATENCY=4 and LATENCY=0).
module tb_pmem_burst_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_s  [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [3:0]  be_s    [2];
    logic [31:0] wd_s    [2];
    logic [31:0] rdata   [2];
    logic        resp    [2];
    logic        perr    [2];

    logic [31:0] model [2][2048];
    logic [31:0] wbuf  [8];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pmem_burst_responder #(.LATENCY(4), .DEPTH_LINES(256)) dut_lat4 (
        .clk(clk), .rst(rst_n), .mem_address(addr_s[0]), .mem_read(rd_s[0]),
        .mem_write(wr_s[0]), .mem_byte_enable(be_s[0]), .mem_wdata(wd_s[0]),
        .mem_rdata(rdata[0]), .mem_resp(resp[0]), .protocol_err(perr[0])
    );

    pmem_burst_responder #(.LATENCY(0), .DEPTH_LINES(256)) dut_lat0 (
        .clk(clk), .rst(rst_n), .mem_address(addr_s[1]), .mem_read(rd_s[1]),
        .mem_write(wr_s[1]), .mem_byte_enable(be_s[1]), .mem_wdata(wd_s[1]),
        .mem_rdata(rdata[1]), .mem_resp(resp[1]), .protocol_err(perr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One burst; the request drops during beat 'cut' (8 = full burst), optionally via reset.
    task automatic burst(input int sel, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input int cut, input bit cut_rst);
        int lat;
        int line;
        logic [31:0] m;
        lat  = (sel == 1) ? 0 : 4;
        line = int'(addr[12:5]);
        @(negedge clk);
        addr_s[sel] = addr; be_s[sel] = be; rd_s[sel] = !wr; wr_s[sel] = wr; wd_s[sel] = '0;
        #1 chk("req_cycle_resp", 32'(resp[sel]), 32'd0);
        chk("req_cycle_perr", 32'(perr[sel]), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            addr_s[sel] = $urandom; be_s[sel] = 4'($urandom);
            #1 chk("latency_resp", 32'(resp[sel]), 32'd0);
            chk("latency_rdata", rdata[sel], 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr_s[sel] = $urandom; be_s[sel] = 4'($urandom);
            if (i == cut) begin
                if (cut_rst) begin
                    rst_n = 1'b0;
                    #1 chk("reset_resp", 32'(resp[sel]), 32'd0);
                    chk("reset_rdata", rdata[sel], 32'd0);
                    chk("reset_perr", 32'(perr[sel]), 32'd0);
                    rd_s[sel] = 1'b0; wr_s[sel] = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                rd_s[sel] = 1'b0; wr_s[sel] = 1'b0;
                @(negedge clk);
                #1 chk("abort_resp", 32'(resp[sel]), 32'd0);
                chk("abort_rdata", rdata[sel], 32'd0);
                return;
            end
            wd_s[sel] = wbuf[i];
            #1 chk("beat_resp", 32'(resp[sel]), 32'd1);
            if (!wr) begin
                chk("beat_rdata", rdata[sel], model[sel][line*8+i]);
            end else begin
                m = model[sel][line*8+i];
                for (int b = 0; b < 4; b++)
                    if (be[b]) m[8*b +: 8] = wbuf[i][8*b +: 8];
                model[sel][line*8+i] = m;
            end
        end
        @(negedge clk);
        #1 chk("done_resp", 32'(resp[sel]), 32'd0);
        chk("done_rdata", rdata[sel], 32'd0);
        rd_s[sel] = 1'b0; wr_s[sel] = 1'b0;
        @(negedge clk);
        #1 chk("post_done_resp", 32'(resp[sel]), 32'd0);
    endtask

    task automatic rand_wbuf();
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    endtask

    function automatic logic [31:0] line_addr(input int line);
        logic [31:0] a;
        a = $urandom;
        a[12:5] = 8'(line);
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lines0 [4] = '{2, 4, 7, 255};
        int lines1 [2] = '{255, 3};
        int sel, ln, cut;
        bit wr;

        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            addr_s[s] = '0; rd_s[s] = 1'b0; wr_s[s] = 1'b0; be_s[s] = '0; wd_s[s] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_resp", 32'(resp[s]), 32'd0);
            chk("rst_rdata", rdata[s], 32'd0);
            chk("rst_perr", 32'(perr[s]), 32'd0);
        end
        rd_s[0] = 1'b1; wr_s[0] = 1'b1;
        #1 chk("rst_perr_both_req", 32'(perr[0]), 32'd0);
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Line 0x40: incrementing pattern, then read back
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1111_1111 * 32'(i + 1);
        burst(0, 1'b1, 32'h0000_0040, 4'hF, 8, 1'b0);
        burst(0, 1'b0, 32'h0000_0040, 4'hF, 8, 1'b0);

        // Line 0x80: all ones, then zeros through byte mask 0101
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hFFFF_FFFF;
        burst(0, 1'b1, 32'h0000_0080, 4'hF, 8, 1'b0);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h0000_0000;
        burst(0, 1'b1, 32'h0000_0080, 4'h5, 8, 1'b0);
        burst(0, 1'b0, 32'h0000_0080, 4'hF, 8, 1'b0);

        // Both requests at once in IDLE
        @(negedge clk);
        rd_s[0] = 1'b1; wr_s[0] = 1'b1;
        #1 chk("perr_pulse", 32'(perr[0]), 32'd1);
        chk("perr_resp", 32'(resp[0]), 32'd0);
        @(negedge clk);
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        #1 chk("perr_clear", 32'(perr[0]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 chk("perr_no_accept", 32'(resp[0]), 32'd0);
        end

        // Read aborted after beat 3, then a normal read
        burst(0, 1'b0, 32'h0000_0040, 4'hF, 4, 1'b0);
        burst(0, 1'b0, 32'h0000_0040, 4'hF, 8, 1'b0);

        // Reset during beat 5 of a write
        rand_wbuf();
        burst(0, 1'b1, 32'h0000_0040, 4'hF, 5, 1'b1);
        burst(0, 1'b0, 32'h0000_0040, 4'hF, 8, 1'b0);

        // Zero-latency build: top line, upper address bits ignored
        rand_wbuf();
        burst(1, 1'b1, 32'h0000_1FE0, 4'hF, 8, 1'b0);
        burst(1, 1'b0, 32'h0000_1FE0, 4'hF, 8, 1'b0);
        burst(1, 1'b0, 32'hABC0_1FF7, 4'hF, 8, 1'b0);

        rand_wbuf();
        burst(0, 1'b1, 32'h0000_00E0, 4'hF, 8, 1'b0);
        rand_wbuf();
        burst(0, 1'b1, 32'h5000_1FE0, 4'hF, 8, 1'b0);
        rand_wbuf();
        burst(1, 1'b1, 32'h0000_0060, 4'hF, 8, 1'b0);

        // Random mix of reads, masked writes and aborts on initialised lines
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 1));
            ln  = (sel == 0) ? lines0[$urandom_range(0, 3)] : lines1[$urandom_range(0, 1)];
            wr  = 1'($urandom);
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            rand_wbuf();
            burst(sel, wr, line_addr(ln), 4'($urandom), cut, 1'b0);
        end
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 2; k++)
                burst(s, 1'b0, line_addr((s == 0) ? lines0[k] : lines1[k]), 4'hF, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
